// File: rtl/iob2axi.sv
`timescale 1ns/1ps
// iob2axi: IOb-bus slave to AXI4 master bridge.
// Each accepted IOb request becomes one single-beat AXI4 transaction
// (AW/W/B for writes, AR/R for reads). Only one transaction is in flight.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   iob_*               IOb slave side: avalid/addr/wdata/wstrb in,
//                       ready/rvalid/rdata out (wstrb==0 means read)
//   err_o               one-cycle pulse on a nonzero bresp/rresp
//   m_axi_*             AXI4 master side, single-beat INCR bursts only
module iob2axi #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH = 1,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    // IOb slave
    input  logic                    iob_avalid_i,
    input  logic [ADDR_WIDTH-1:0]   iob_addr_i,
    input  logic [DATA_WIDTH-1:0]   iob_wdata_i,
    input  logic [STRB_WIDTH-1:0]   iob_wstrb_i,
    output logic                    iob_ready_o,
    output logic                    iob_rvalid_o,
    output logic [DATA_WIDTH-1:0]   iob_rdata_o,
    output logic                    err_o,
    // AXI write address
    output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // AXI write response
    input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // AXI read address
    output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // AXI read data
    input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    localparam logic [2:0] SIZE = 3'($clog2(STRB_WIDTH));

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  aw_pend;
    logic                  w_pend;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  err;

    // A channel counts as done once its flag is clear or it handshakes now,
    // so simultaneous AW and W handshakes move straight to WRESP.
    logic aw_done, w_done;
    assign aw_done = !aw_pend || m_axi_awready;
    assign w_done  = !w_pend  || m_axi_wready;

    // IDs and rlast carry no information for single-beat, single-ID traffic.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (iob_avalid_i) begin
                        addr <= iob_addr_i;
                        if (|iob_wstrb_i) begin
                            wdata   <= iob_wdata_i;
                            wstrb   <= iob_wstrb_i;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            state <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    if (m_axi_awready) aw_pend <= 1'b0;
                    if (m_axi_wready)  w_pend  <= 1'b0;
                    if (aw_done && w_done) state <= WRESP;
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        err   <= |m_axi_bresp;
                        state <= IDLE;
                    end
                end
                RADDR: begin
                    if (m_axi_arready) state <= RDATA;
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        rdata  <= m_axi_rdata;
                        rvalid <= 1'b1;
                        err    <= |m_axi_rresp;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode registered state only, so reset drops them
    // immediately and no AXI input reaches an AXI output combinationally.
    assign iob_ready_o   = (state == IDLE);
    assign iob_rvalid_o  = rvalid;
    assign iob_rdata_o   = rdata;
    assign err_o         = err;

    assign m_axi_awvalid = (state == WRITE) && aw_pend;
    assign m_axi_wvalid  = (state == WRITE) && w_pend;
    assign m_axi_bready  = (state == WRESP);
    assign m_axi_arvalid = (state == RADDR);
    assign m_axi_rready  = (state == RDATA);

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'd0;

    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = wstrb;
    assign m_axi_wlast   = 1'b1;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'd0;

endmodule
